sync_fifo_prog: RTL and testbench

//  Single-clock FIFO for same-domain buffering between pipeline stages.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sfifo_ram.sv | 28 ++
 rtl/sync_fifo_prog.sv | 174 +++++++++++++++++
 tb/tb_sync_fifo_prog.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and status type for the single-clock programmable FIFO.
package sync_fifo_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Flag state after reset or flush, independent of the threshold inputs.
    localparam fifo_status_t STATUS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/sfifo_ram.sv
// Storage array for the single-clock FIFO: registered write port and an
// asynchronous read port so the same array serves both read modes.
module sfifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard / first-word-fall-through read mode,
// occupancy count, programmable almost flags, flush and sticky error flags.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int FWFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    input  logic [AW:0]   af_thresh,
    input  logic [AW:0]   ae_thresh,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};

    logic [AW:0]   wptr_r, rptr_r, count_r;
    logic [AW:0]   wptr_n_s, rptr_n_s, count_n_s;
    fifo_status_t  status_r, status_n_s;
    logic          rd_acc_s, wr_acc_s, mem_we_s;
    logic          overflow_r, underflow_r, overflow_n_s, underflow_n_s;
    logic [DW-1:0] ram_rdata_s;

    // Accept decisions and next pointer / occupancy values.
    always_comb begin
        rd_acc_s  = rd_en & ~status_r.empty;
        wr_acc_s  = wr_en & (~status_r.full | rd_acc_s);
        mem_we_s  = wr_acc_s & ~flush;
        wptr_n_s  = wptr_r;
        rptr_n_s  = rptr_r;
        count_n_s = count_r;
        if (flush) begin
            wptr_n_s  = PTR_ZERO;
            rptr_n_s  = PTR_ZERO;
            count_n_s = PTR_ZERO;
        end else begin
            if (wr_acc_s) begin
                wptr_n_s = wptr_r + PTR_ONE;
            end else begin
                wptr_n_s = wptr_r;
            end
            if (rd_acc_s) begin
                rptr_n_s = rptr_r + PTR_ONE;
            end else begin
                rptr_n_s = rptr_r;
            end
            count_n_s = count_r + {{AW{1'b0}}, wr_acc_s} - {{AW{1'b0}}, rd_acc_s};
        end
    end

    // Next flag values: full/empty from the pointer compare, almost flags from count.
    always_comb begin
        status_n_s = STATUS_RESET;
        if (flush) begin
            status_n_s = STATUS_RESET;
        end else begin
            status_n_s.full         = (wptr_n_s[AW] != rptr_n_s[AW]) &&
                                      (wptr_n_s[AW-1:0] == rptr_n_s[AW-1:0]);
            status_n_s.empty        = (wptr_n_s == rptr_n_s);
            status_n_s.almost_full  = (count_n_s >= af_thresh);
            status_n_s.almost_empty = (count_n_s <= ae_thresh);
        end
    end

    // Sticky error flags: a new error in the same cycle beats clr_err.
    always_comb begin
        overflow_n_s  = overflow_r;
        underflow_n_s = underflow_r;
        if (!flush && wr_en && !wr_acc_s) begin
            overflow_n_s = 1'b1;
        end else if (clr_err) begin
            overflow_n_s = 1'b0;
        end else begin
            overflow_n_s = overflow_r;
        end
        if (!flush && rd_en && status_r.empty) begin
            underflow_n_s = 1'b1;
        end else if (clr_err) begin
            underflow_n_s = 1'b0;
        end else begin
            underflow_n_s = underflow_r;
        end
    end

    // Pointer, count, flag and error state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r      <= PTR_ZERO;
            rptr_r      <= PTR_ZERO;
            count_r     <= PTR_ZERO;
            status_r    <= STATUS_RESET;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wptr_r      <= wptr_n_s;
            rptr_r      <= rptr_n_s;
            count_r     <= count_n_s;
            status_r    <= status_n_s;
            overflow_r  <= overflow_n_s;
            underflow_r <= underflow_n_s;
        end
    end

    sfifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wptr_r[AW-1:0]),
        .wdata (wdata),
        .raddr (rptr_r[AW-1:0]),
        .rdata (ram_rdata_s)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; masked to zero while empty so stale
            // contents never appear and reset gives rdata = 0.
            always_comb begin
                if (status_r.empty) begin
                    rdata = {DW{1'b0}};
                end else begin
                    rdata = ram_rdata_s;
                end
                rvalid = ~status_r.empty;
            end
        end else begin : g_std
            logic [DW-1:0] rdata_r;
            logic          rvalid_r;

            // Registered read: data captured on an accepted pop, held otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_r  <= {DW{1'b0}};
                    rvalid_r <= 1'b0;
                end else begin
                    rvalid_r <= rd_acc_s & ~flush;
                    if (rd_acc_s && !flush) begin
                        rdata_r <= ram_rdata_s;
                    end
                end
            end

            assign rdata  = rdata_r;
            assign rvalid = rvalid_r;
        end
    endgenerate

    assign full         = status_r.full;
    assign empty        = status_r.empty;
    assign almost_full  = status_r.almost_full;
    assign almost_empty = status_r.almost_empty;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: dut0 in standard read mode, dut1 in FWFT mode.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] af_thresh = 5'd12;
    logic [4:0] ae_thresh = 5'd2;

    logic       flush0 = 1'b0, wr_en0 = 1'b0, rd_en0 = 1'b0, clr_err0 = 1'b0;
    logic [7:0] wdata0 = 8'h00;
    logic [7:0] rdata0;
    logic       rvalid0, full0, empty0, afull0, aempty0, ovf0, unf0;
    logic [4:0] count0;

    logic       flush1 = 1'b0, wr_en1 = 1'b0, rd_en1 = 1'b0, clr_err1 = 1'b0;
    logic [7:0] wdata1 = 8'h00;
    logic [7:0] rdata1;
    logic       rvalid1, full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [4:0] count1;

    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    sync_fifo_prog #(.DW(8), .AW(4), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .wr_en(wr_en0), .wdata(wdata0),
        .rd_en(rd_en0), .rdata(rdata0), .rvalid(rvalid0), .full(full0),
        .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
        .count(count0), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err0)
    );

    sync_fifo_prog #(.DW(8), .AW(4), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .wr_en(wr_en1), .wdata(wdata1),
        .rd_en(rd_en1), .rdata(rdata1), .rvalid(rvalid1), .full(full1),
        .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
        .count(count1), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rdata0"},  rdata0,  0);
        check({tag, " rvalid0"}, rvalid0, 0);
        check({tag, " empty0"},  empty0,  1);
        check({tag, " aempty0"}, aempty0, 1);
        check({tag, " full0"},   full0,   0);
        check({tag, " afull0"},  afull0,  0);
        check({tag, " count0"},  count0,  0);
        check({tag, " ovf0"},    ovf0,    0);
        check({tag, " unf0"},    unf0,    0);
        check({tag, " rdata1"},  rdata1,  0);
        check({tag, " rvalid1"}, rvalid1, 0);
        check({tag, " empty1"},  empty1,  1);
        check({tag, " count1"},  count1,  0);
    endtask

    // Standard-mode monitor: every rvalid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rvalid0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL mon0_unexpected: got rdata 0x%0h expected no rvalid", rdata0);
            end else begin
                logic [7:0] exp0;
                exp0 = q0.pop_front();
                if (rdata0 !== exp0) begin
                    errors++;
                    $display("FAIL mon0_data: got 0x%0h expected 0x%0h", rdata0, exp0);
                end
            end
        end
    end

    // FWFT monitor: the word shown while rd_en is high is the one being popped.
    always @(negedge clk) begin
        if (!rst && rvalid1 && rd_en1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL mon1_unexpected: got rdata 0x%0h expected no pop", rdata1);
            end else begin
                logic [7:0] exp1;
                exp1 = q1.pop_front();
                if (rdata1 !== exp1) begin
                    errors++;
                    $display("FAIL mon1_data: got 0x%0h expected 0x%0h", rdata1, exp1);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // FWFT: write into empty is visible the next cycle without rd_en.
        wr_en1 = 1'b1; wdata1 = 8'hA5; q1.push_back(8'hA5);
        tick();
        wr_en1 = 1'b0;
        check("fwft_rvalid", rvalid1, 1);
        check("fwft_rdata",  rdata1,  8'hA5);
        check("fwft_count",  count1,  1);
        tick();
        check("fwft_hold", rdata1, 8'hA5);
        wr_en1 = 1'b1; wdata1 = 8'hB6; q1.push_back(8'hB6);
        tick();
        wr_en1 = 1'b0; rd_en1 = 1'b1;
        tick();
        check("fwft_next_word", rdata1, 8'hB6);
        tick();
        rd_en1 = 1'b0;
        check("fwft_empty",  empty1,  1);
        check("fwft_rvalid0", rvalid1, 0);

        // Empty + wr_en + rd_en: write accepted, read rejected.
        wr_en0 = 1'b1; rd_en0 = 1'b1; wdata0 = 8'h5A; q0.push_back(8'h5A);
        tick();
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        check("empty_wr_rd_count", count0, 1);
        check("empty_wr_rd_unf",   unf0,   1);
        check("empty_wr_rd_rvalid", rvalid0, 0);
        clr_err0 = 1'b1;
        tick();
        clr_err0 = 1'b0;
        check("clr_err_unf", unf0, 0);
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        tick();
        check("single_drain_count", count0, 0);

        // Fill 16: almost_full at 12, full after the 16th edge.
        for (int i = 0; i < 16; i++) begin
            wr_en0 = 1'b1; wdata0 = 8'(i); q0.push_back(8'(i));
            tick();
            check("fill_count", count0, i + 1);
            check("fill_afull", afull0, (i + 1 >= 12) ? 1 : 0);
            check("fill_full",  full0,  (i == 15) ? 1 : 0);
        end
        wr_en0 = 1'b0;

        // Drain 16 in order, then a 17th read underflows.
        for (int i = 0; i < 16; i++) begin
            rd_en0 = 1'b1;
            tick();
            check("drain_count",  count0,  15 - i);
            check("drain_aempty", aempty0, (15 - i <= 2) ? 1 : 0);
        end
        rd_en0 = 1'b0;
        tick();
        check("drain_empty", empty0, 1);
        check("drain_q0", q0.size(), 0);
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        check("underflow_set", unf0, 1);
        check("underflow_count", count0, 0);
        clr_err0 = 1'b1;
        tick();
        clr_err0 = 1'b0;

        // Full + wr_en + rd_en keeps count at 16; 0x77 comes out last.
        for (int i = 0; i < 16; i++) begin
            wr_en0 = 1'b1; wdata0 = 8'(8'h10 + i); q0.push_back(8'(8'h10 + i));
            tick();
        end
        rd_en0 = 1'b1; wdata0 = 8'h77; q0.push_back(8'h77);
        tick();
        rd_en0 = 1'b0;
        check("full_wr_rd_count", count0, 16);
        check("full_wr_rd_ovf",   ovf0,   0);
        check("full_wr_rd_full",  full0,  1);
        wdata0 = 8'hEE;
        tick();
        wr_en0 = 1'b0;
        check("overflow_set",   ovf0,   1);
        check("overflow_count", count0, 16);
        clr_err0 = 1'b1;
        tick();
        clr_err0 = 1'b0;
        check("clr_err_ovf", ovf0, 0);
        rd_en0 = 1'b1;
        repeat (16) tick();
        rd_en0 = 1'b0;
        tick();
        check("full_drain_q0", q0.size(), 0);

        // Wrap pointers over three fill/drain rounds of 8.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                wr_en0 = 1'b1; wdata0 = 8'(8'h40 + r * 8 + i); q0.push_back(8'(8'h40 + r * 8 + i));
                tick();
            end
            wr_en0 = 1'b0;
            check("wrap_count8", count0, 8);
            rd_en0 = 1'b1;
            repeat (8) tick();
            rd_en0 = 1'b0;
            tick();
            check("wrap_empty", empty0, 1);
        end

        // Flush mid-stream discards contents; a write during flush is ignored.
        for (int i = 0; i < 5; i++) begin
            wr_en0 = 1'b1; wdata0 = 8'(8'h90 + i);
            tick();
        end
        flush0 = 1'b1; wdata0 = 8'hEE;
        tick();
        flush0 = 1'b0; wr_en0 = 1'b0;
        check("flush_count",  count0,  0);
        check("flush_empty",  empty0,  1);
        check("flush_full",   full0,   0);
        check("flush_aempty", aempty0, 1);
        wr_en0 = 1'b1; wdata0 = 8'h3C; q0.push_back(8'h3C);
        tick();
        wr_en0 = 1'b0; rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        tick();
        check("post_flush_count", count0, 0);
        check("post_flush_q0", q0.size(), 0);

        // Asynchronous reset mid-burst clears outputs before the next edge.
        for (int i = 0; i < 3; i++) begin
            wr_en0 = 1'b1; wdata0 = 8'(8'hC0 + i);
            wr_en1 = 1'b1; wdata1 = 8'(8'hD0 + i);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        wr_en0 = 1'b0; wr_en1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("after_reset_count0", count0, 0);
        check("after_reset_q1", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
